// File: rtl/btn_gen_pkg.sv
// Shared types for the button-press generator: command ops, FSM states and
// the queued command record.
package btn_gen_pkg;

  typedef enum logic [1:0] {
    OP_NOP     = 2'd0,
    OP_PRESS_M = 2'd1,
    OP_PRESS_R = 2'd2,
    OP_WAIT    = 2'd3
  } btn_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_HOLD = 2'd2,
    ST_WAIT = 2'd3
  } btn_gen_state_e;

  typedef struct packed {
    btn_op_e    op;
    logic [3:0] arg;
  } btn_cmd_t;

  // A WAIT of zero ticks is stretched to one so the FSM always sees a tick.
  function automatic logic [3:0] wait_ticks(input logic [3:0] arg);
    return (arg == 4'd0) ? 4'd1 : arg;
  endfunction

endpackage

// File: rtl/btn_cmd_fifo.sv
// Synchronous show-ahead FIFO of btn_cmd_t records; DEPTH must be a power of
// two so the pointers wrap naturally.
module btn_cmd_fifo
  import btn_gen_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  btn_cmd_t      wr_data,
  input  logic          rd_en,
  output btn_cmd_t      rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  btn_cmd_t mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_wr, do_rd;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q];

endmodule

// File: rtl/btn_press_gen.sv
// Button-press generator: queued commands become timed btn_m/btn_r presses
// paced by a divided-clock tick. Define BTN_GEN_FIFO_EN for a FIFO queue.
module btn_press_gen
  import btn_gen_pkg::*;
#(
  parameter int DIV_BIT    = 5,
  parameter int GAP_TICKS  = 2,
  parameter int HOLD_TICKS = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_arg,
  output logic       btn_m,
  output logic       btn_r,
  output logic       busy,
  output logic       done,
  output logic [3:0] pending
);

  localparam int TMAX_GH = (GAP_TICKS > HOLD_TICKS) ? GAP_TICKS : HOLD_TICKS;
  localparam int TMAX    = (TMAX_GH > 15) ? TMAX_GH : 15;
  localparam int TCNT_W  = $clog2(TMAX + 1);

  logic [DIV_BIT:0] div_cnt_q, div_cnt_d;
  logic             tick;

  btn_cmd_t in_cmd, q_head;
  logic     q_empty, push, pop;

  btn_gen_state_e    state_q, state_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [3:0]        wait_len_q, wait_len_d;
  logic              sel_r_q, sel_r_d;
  logic              btn_m_q, btn_m_d, btn_r_q, btn_r_d, done_q, done_d;

  assign div_cnt_d = div_cnt_q + 1'b1;
  assign tick      = &div_cnt_q;

  assign in_cmd = '{op: btn_op_e'(cmd_op), arg: cmd_arg};
  assign push   = cmd_valid && cmd_ready;

`ifdef BTN_GEN_FIFO_EN
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  logic             q_full;
  logic [CNT_W-1:0] q_count;

  btn_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (in_cmd),
    .rd_en   (pop),
    .rd_data (q_head),
    .full    (q_full),
    .empty   (q_empty),
    .count   (q_count)
  );

  assign cmd_ready = !q_full;
  assign pending   = (int'(q_count) > 15) ? 4'd15 : 4'(q_count);
`else
  logic     hold_valid_q, hold_valid_d;
  btn_cmd_t hold_cmd_q, hold_cmd_d;
  logic     unused_cfg;

  assign unused_cfg = (FIFO_DEPTH > 0);

  // Accept only happens while empty, so push and pop never coincide.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_cmd_d   = hold_cmd_q;
    if (push) begin
      hold_valid_d = 1'b1;
      hold_cmd_d   = in_cmd;
    end else if (pop) begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_q <= 1'b0;
      hold_cmd_q   <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_cmd_q   <= hold_cmd_d;
    end
  end

  assign q_empty   = !hold_valid_q;
  assign q_head    = hold_cmd_q;
  assign cmd_ready = !hold_valid_q;
  assign pending   = {3'b000, hold_valid_q};
`endif

  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    wait_len_d = wait_len_q;
    sel_r_d    = sel_r_q;
    btn_m_d    = btn_m_q;
    btn_r_d    = btn_r_q;
    done_d     = 1'b0;
    pop        = 1'b0;
    if (tick) begin
      unique case (state_q)
        ST_IDLE: pop = !q_empty;
        ST_GAP: begin
          if (tcnt_q == TCNT_W'(GAP_TICKS)) begin
            if (sel_r_q) btn_r_d = 1'b1;
            else         btn_m_d = 1'b1;
            state_d = ST_HOLD;
            tcnt_d  = TCNT_W'(1);
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (tcnt_q == TCNT_W'(HOLD_TICKS)) begin
            btn_m_d = 1'b0;
            btn_r_d = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
            pop     = !q_empty;
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (tcnt_q == TCNT_W'(wait_len_q)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
            pop     = !q_empty;
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Starting a popped command overrides the completion's return to IDLE.
    if (pop) begin
      unique case (q_head.op)
        OP_PRESS_M: begin
          state_d = ST_GAP;
          sel_r_d = 1'b0;
          tcnt_d  = TCNT_W'(1);
        end
        OP_PRESS_R: begin
          state_d = ST_GAP;
          sel_r_d = 1'b1;
          tcnt_d  = TCNT_W'(1);
        end
        OP_WAIT: begin
          state_d    = ST_WAIT;
          tcnt_d     = TCNT_W'(1);
          wait_len_d = wait_ticks(q_head.arg);
        end
        default: begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q  <= '0;
      state_q    <= ST_IDLE;
      tcnt_q     <= '0;
      wait_len_q <= 4'd1;
      sel_r_q    <= 1'b0;
      btn_m_q    <= 1'b0;
      btn_r_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      wait_len_q <= wait_len_d;
      sel_r_q    <= sel_r_d;
      btn_m_q    <= btn_m_d;
      btn_r_q    <= btn_r_d;
      done_q     <= done_d;
    end
  end

  assign btn_m = btn_m_q;
  assign btn_r = btn_r_q;
  assign done  = done_q;
  assign busy  = (state_q != ST_IDLE) || !q_empty;

endmodule
